// File: rtl/bus_slave_responder_pkg.sv
// bus_slave_responder_pkg: shared bus encodings, slave FSM state type and counter width
`ifndef BUS_SLAVE_BUS_DEFS
`define BUS_SLAVE_BUS_DEFS
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`define AS_ENABLE 1'b1
`define AS_DISABLE 1'b0
`define RW_READ 1'b1
`define RW_WRITE 1'b0
`define CS_ENABLE 1'b1
`define CS_DISABLE 1'b0
`define RDY_ENABLE 1'b1
`define RDY_DISABLE 1'b0
`define BUS_SLV_IDLE 2'd0
`define BUS_SLV_WAIT 2'd1
`define BUS_SLV_RESP 2'd2
`define BUS_SLV_CNT_W 4
`endif

package bus_slave_responder_pkg;
  typedef enum logic [1:0] {
    S_IDLE = `BUS_SLV_IDLE,
    S_WAIT = `BUS_SLV_WAIT,
    S_RESP = `BUS_SLV_RESP
  } state_e;
  localparam int CNT_W = `BUS_SLV_CNT_W;
  function automatic logic bus_active(input logic cs, input logic as_s);
    return cs == `CS_ENABLE && as_s == `AS_ENABLE;
  endfunction
endpackage

// File: rtl/bus_slave_regfile.sv
// bus_slave_regfile: 2^AW word bank, synchronous write, combinational read, async clear
module bus_slave_regfile #(
  parameter int AW = 3,
  parameter int DW = `DATA_WIDTH
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  // bank storage: cleared on reset, one word written per enabled edge
  always_ff @(posedge clk or negedge reset_)
    if (!reset_)
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    else if (we_i)
      mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/bus_slave_responder.sv
// bus_slave_responder: bus slave endpoint with wait states and register bank; BUS_SLAVE_ERR_EN adds s_err for out-of-range addresses
module bus_slave_responder
  import bus_slave_responder_pkg::*;
#(
  parameter int REG_AW      = 3,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   s_cs,
  input  logic                   s_as,
  input  logic                   s_rw,
  input  logic [`ADDR_WIDTH-1:0] s_addr,
  input  logic [`DATA_WIDTH-1:0] s_wr_data,
  output logic [`DATA_WIDTH-1:0] s_rd_data,
  output logic                   s_rdy
`ifdef BUS_SLAVE_ERR_EN
  ,
  output logic                   s_err
`endif
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_AW-1:0] addr_q;
  logic rw_q;
  logic [`DATA_WIDTH-1:0] data_q;
  logic [`DATA_WIDTH-1:0] bank_rdata;
  logic [`DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic rdy_q, rdy_d;
  logic active, cap, resp, we, bad;
  assign active = bus_active(s_cs, s_as);
  assign cap = state_q == S_IDLE && active;
`ifdef BUS_SLAVE_ERR_EN
  logic bad_q, err_q, err_d;
  // out-of-range flag captured with the access, error registered alongside ready
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (cap) bad_q <= |s_addr[`ADDR_WIDTH-1:REG_AW];
      err_q <= err_d;
    end
  assign bad = bad_q;
  assign err_d = resp && bad_q;
  assign s_err = err_q;
`else
  logic unused_hi_addr;
  assign unused_hi_addr = ^s_addr[`ADDR_WIDTH-1:REG_AW];
  assign bad = 1'b0;
`endif
  // state and wait counter
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  // next state: capture from idle, count wait states, abort if the bus releases early
  always_comb begin
    state_d = state_q == S_IDLE ? (active ? (WAIT_CYCLES == 0 ? S_RESP : S_WAIT) : S_IDLE)
            : state_q == S_WAIT ? (!active ? S_IDLE : cnt_q == '0 ? S_RESP : S_WAIT)
            : S_IDLE;
    cnt_d = cap ? CNT_W'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1)
          : (state_q == S_WAIT && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  end
  // access capture: later input changes are ignored until the next access
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      addr_q <= '0;
      rw_q <= 1'b0;
      data_q <= '0;
    end else if (cap) begin
      addr_q <= s_addr[REG_AW-1:0];
      rw_q <= s_rw;
      data_q <= s_wr_data;
    end
  // response: write enable, ready and read data for the registered outputs
  always_comb begin
    resp = state_q == S_RESP;
    we = resp && rw_q == `RW_WRITE && !bad;
    rdy_d = resp ? `RDY_ENABLE : `RDY_DISABLE;
    rd_data_d = (resp && rw_q == `RW_READ && !bad) ? bank_rdata : '0;
  end
  // registered bus outputs, no combinational path from inputs
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      rdy_q <= `RDY_DISABLE;
      rd_data_q <= '0;
    end else begin
      rdy_q <= rdy_d;
      rd_data_q <= rd_data_d;
    end
  assign s_rdy = rdy_q;
  assign s_rd_data = rd_data_q;
  bus_slave_regfile #(.AW(REG_AW), .DW(`DATA_WIDTH)) u_regfile (
    .clk(clk),
    .reset_(reset_),
    .we_i(we),
    .waddr_i(addr_q),
    .wdata_i(data_q),
    .raddr_i(addr_q),
    .rdata_o(bank_rdata)
  );
endmodule

// File: tb/tb_bus_slave_responder.sv
// tb_bus_slave_responder: scoreboard bench over three slaves with 1, 0 and 3 wait states
module tb_bus_slave_responder;
  localparam int NI = 3;
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;
  function automatic int wc(input int i);
    return i == 0 ? 1 : i == 1 ? 0 : 3;
  endfunction
  typedef struct {
    int inst;
    logic [31:0] data;
    logic err;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic cs [NI];
  logic as_s [NI];
  logic rw [NI];
  logic [31:0] addr [NI];
  logic [31:0] wdata [NI];
  logic [31:0] rdata [NI];
  logic rdy [NI];
  logic err [NI];
  exp_t exp_q [$];
  exp_t mon_e;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    bus_slave_responder #(.REG_AW(3), .WAIT_CYCLES(wc(g))) u_dut (
      .clk(clk),
      .reset_(rst_n),
      .s_cs(cs[g]),
      .s_as(as_s[g]),
      .s_rw(rw[g]),
      .s_addr(addr[g]),
      .s_wr_data(wdata[g]),
      .s_rd_data(rdata[g]),
      .s_rdy(rdy[g])
`ifdef BUS_SLAVE_ERR_EN
      ,
      .s_err(err[g])
`endif
    );
`ifndef BUS_SLAVE_ERR_EN
    assign err[g] = 1'b0;
`endif
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic drive(input int i, input logic c, input logic a, input logic r, input logic [31:0] ad, input logic [31:0] d);
    cs[i] = c;
    as_s[i] = a;
    rw[i] = r;
    addr[i] = ad;
    wdata[i] = d;
  endtask
  task automatic idle(input int i);
    drive(i, 1'b0, 1'b0, RD, 32'h0, 32'h0);
  endtask
  task automatic access(input int i, input logic r, input logic [31:0] ad, input logic [31:0] d, input logic [31:0] ed, input logic ee);
    drive(i, 1'b1, 1'b1, r, ad, d);
    @(posedge clk);
    #1;
    exp_q.push_back('{i, ed, ee, cyc + wc(i) + 1});
    repeat (wc(i) + 1) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk)
    if (rst_n === 1'b1)
      for (int i = 0; i < NI; i++)
        if (rdy[i] === 1'b1) begin
          if (exp_q.size() == 0 || exp_q[0].inst != i) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rdy: inst %0d cycle %0d data %h, no access pending", i, cyc, rdata[i]);
          end else begin
            mon_e = exp_q.pop_front();
            chk($sformatf("rd_data[%0d]", i), rdata[i], mon_e.data);
            chk($sformatf("err[%0d]", i), {31'b0, err[i]}, {31'b0, mon_e.err});
            chk($sformatf("rdy_cycle[%0d]", i), cyc, mon_e.cyc);
          end
        end
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) idle(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_rdy[%0d]", i), {31'b0, rdy[i]}, 32'h0);
      chk($sformatf("reset_rd_data[%0d]", i), rdata[i], 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(0, WR, 32'd2, 32'h0000_00A5, 32'h0, 1'b0);
    idle(0);
    access(0, RD, 32'd2, 32'h0, 32'h0000_00A5, 1'b0);
    access(0, RD, 32'd3, 32'h0, 32'h0, 1'b0);
    idle(0);
    @(posedge clk);
    #1;
    access(1, WR, 32'd7, 32'h1234_5678, 32'h0, 1'b0);
    access(1, RD, 32'd7, 32'h0, 32'h1234_5678, 1'b0);
    idle(1);
    @(posedge clk);
    #1;
    drive(2, 1'b1, 1'b1, WR, 32'd1, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    drive(2, 1'b1, 1'b0, WR, 32'd1, 32'hDEAD_BEEF);
    repeat (6) @(posedge clk);
    #1;
    access(2, RD, 32'd1, 32'h0, 32'h0, 1'b0);
    idle(2);
    access(2, WR, 32'd4, 32'h5, 32'h0, 1'b0);
    access(2, RD, 32'd4, 32'h0, 32'h5, 1'b0);
    drive(2, 1'b1, 1'b1, WR, 32'd4, 32'h6);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("midreset_rdy[%0d]", i), {31'b0, rdy[i]}, 32'h0);
      chk($sformatf("midreset_rd_data[%0d]", i), rdata[i], 32'h0);
    end
    repeat (2) @(posedge clk);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(2, RD, 32'd4, 32'h0, 32'h0, 1'b0);
    idle(2);
`ifdef BUS_SLAVE_ERR_EN
    access(0, WR, 32'd8, 32'd9, 32'h0, 1'b1);
    idle(0);
    access(0, RD, 32'd0, 32'h0, 32'h0, 1'b0);
`else
    access(0, WR, 32'd8, 32'd9, 32'h0, 1'b0);
    idle(0);
    access(0, RD, 32'd0, 32'h0, 32'd9, 1'b0);
`endif
    idle(0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pending_responses", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
